// File: rtl/lin_count_pkg.sv
// Shared constants, state encoding and parity helper for the linear-approximation
// counting engine and its plaintext FIFO.
package lin_count_pkg;

   localparam int DEF_DATA_W     = 64;
   localparam int DEF_NUM_MASKS  = 4;
   localparam int DEF_CNT_W      = 64;
   localparam int DEF_FIFO_DEPTH = 16;

   // Upper bound on the width the parity helper reduces; narrower operands are zero-extended.
   localparam int PAR_MAX_W = 1024;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/lin_count_engine_fifo.sv
// In-flight plaintext FIFO: holds issued plaintexts until their ciphertexts return.
// A push and a pop in the same cycle are both honoured even when full.
module lin_pt_fifo
   import lin_count_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [AW:0]       r_cnt;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign o_head    = r_mem[r_rd];
   assign w_do_push = i_push & (~o_full | i_pop) & ~i_clr;
   assign w_do_pop  = i_pop & ~o_empty & ~i_clr;

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/lin_count_engine.sv
// Linear-approximation counting engine: issues LFSR plaintexts to a cipher core and
// scores each returning ciphertext against NUM_MASKS input/output mask pairs.
//
// state    | meaning
// ST_IDLE  | waiting for start; ciphertexts ignored
// ST_RUN   | issuing plaintexts and counting returning ciphertexts
// ST_DRAIN | all plaintexts issued; waiting for remaining ciphertexts
// ST_DONE  | run complete, done held; start re-arms
module lin_count_engine
   import lin_count_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_MASKS  = DEF_NUM_MASKS,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          restart_block,
   input  logic [DATA_W-1:0]             seed,
   input  logic [DATA_W-1:0]             polynomial,
   input  logic [NUM_MASKS*DATA_W-1:0]   mask_i,
   input  logic [NUM_MASKS*DATA_W-1:0]   mask_o,
   input  logic [CNT_W-1:0]              counter_limit,
   output logic [DATA_W-1:0]             pt_data,
   output logic                          pt_valid,
   input  logic                          pt_ready,
   input  logic [DATA_W-1:0]             ct_data,
   input  logic                          ct_valid,
   output logic [NUM_MASKS*CNT_W-1:0]    counter,
   output logic [CNT_W-1:0]              samples,
   output logic                          done,
   output logic                          error
);

   state_t                        r_state;
   logic [DATA_W-1:0]             r_lfsr;
   logic [DATA_W-1:0]             r_poly;
   logic [NUM_MASKS*DATA_W-1:0]   r_mask_i;
   logic [NUM_MASKS*DATA_W-1:0]   r_mask_o;
   logic [CNT_W-1:0]              r_limit;
   logic [CNT_W-1:0]              r_issued;
   logic [CNT_W-1:0]              r_samples;
   logic                          r_error;

   logic                          w_start_acc;
   logic                          w_clear;
   logic                          w_pt_valid;
   logic                          w_push;
   logic                          w_pop_req;
   logic                          w_pop;
   logic                          w_fifo_full;
   logic                          w_fifo_empty;
   logic [DATA_W-1:0]             w_head;
   logic [DATA_W-1:0]             w_lfsr_next;
   logic [CNT_W-1:0]              w_issued_inc;
   logic [NUM_MASKS-1:0]          w_agree;

   assign w_start_acc  = start & ~restart_block & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_clear      = restart_block | w_start_acc;
   assign w_pt_valid   = (r_state == ST_RUN) & (r_issued < r_limit) & ~w_fifo_full & ~restart_block;
   assign w_push       = w_pt_valid & pt_ready;
   assign w_pop_req    = ct_valid & (r_state != ST_IDLE) & ~w_clear;
   assign w_pop        = w_pop_req & ~w_fifo_empty;
   assign w_lfsr_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? r_poly : '0);
   assign w_issued_inc = r_issued + CNT_W'(1);

   assign pt_data  = r_lfsr;
   assign pt_valid = w_pt_valid;
   assign samples  = r_samples;
   assign done     = (r_state == ST_DONE);
   assign error    = r_error;

   lin_pt_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clr       (w_clear),
      .i_push      (w_push),
      .i_push_data (r_lfsr),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_lfsr    <= '0;
         r_poly    <= '0;
         r_mask_i  <= '0;
         r_mask_o  <= '0;
         r_limit   <= '0;
         r_issued  <= '0;
         r_samples <= '0;
         r_error   <= 1'b0;
      end else if (restart_block) begin
         r_state   <= ST_IDLE;
         r_issued  <= '0;
         r_samples <= '0;
         r_error   <= 1'b0;
      end else if (w_start_acc) begin
         r_poly    <= polynomial;
         r_mask_i  <= mask_i;
         r_mask_o  <= mask_o;
         r_limit   <= counter_limit;
         // An all-zero LFSR would never leave zero, so a zero seed starts from 1.
         r_lfsr    <= (seed == '0) ? DATA_W'(1) : seed;
         r_issued  <= '0;
         r_samples <= '0;
         r_error   <= 1'b0;
         r_state   <= (counter_limit == '0) ? ST_DONE : ST_RUN;
      end else begin
         if (w_push) begin
            r_lfsr   <= w_lfsr_next;
            r_issued <= w_issued_inc;
            if (w_issued_inc == r_limit) begin
               r_state <= ST_DRAIN;
            end
         end
         if (w_pop) begin
            r_samples <= r_samples + CNT_W'(1);
         end
         if ((w_pop_req & w_fifo_empty) | (w_push & w_fifo_full & ~w_pop)) begin
            r_error <= 1'b1;
         end
         if ((r_state == ST_DRAIN) && (r_samples == r_limit)) begin
            r_state <= ST_DONE;
         end
      end
   end

   for (genvar k = 0; k < NUM_MASKS; k++) begin : g_pair
      logic [CNT_W-1:0] r_cnt;

      assign w_agree[k] = ~parity(PAR_MAX_W'((w_head  & r_mask_i[k*DATA_W +: DATA_W]) ^
                                             (ct_data & r_mask_o[k*DATA_W +: DATA_W])));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (w_clear) begin
            r_cnt <= '0;
         end else if (w_pop & w_agree[k]) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign counter[k*CNT_W +: CNT_W] = r_cnt;
   end

endmodule

// File: tb/tb_lin_count_engine.sv
// Directed bench for lin_count_engine with an identity cipher model of configurable
// latency and optional random pt_ready.
module tb_lin_count_engine;

   localparam int DW = 64;
   localparam int NM = 4;
   localparam int CW = 64;
   localparam int FD = 16;
   localparam logic [DW-1:0] POLY = 64'h8000_0000_0000_000D;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic                 restart_block = 1'b0;
   logic [DW-1:0]        seed = '0;
   logic [DW-1:0]        polynomial = '0;
   logic [NM*DW-1:0]     mask_i = '0;
   logic [NM*DW-1:0]     mask_o = '0;
   logic [CW-1:0]        counter_limit = '0;
   logic [DW-1:0]        pt_data;
   logic                 pt_valid;
   logic                 pt_ready = 1'b0;
   logic [DW-1:0]        ct_data = '0;
   logic                 ct_valid = 1'b0;
   logic [NM*CW-1:0]     counter;
   logic [CW-1:0]        samples;
   logic                 done;
   logic                 error;

   int n_cmp  = 0;
   int n_fail = 0;

   bit            cipher_en = 1'b0;
   bit            rnd_ready = 1'b0;
   bit            spur_ct   = 1'b0;
   bit            pv_chk    = 1'b0;
   int            lat       = 1;
   longint        cyc       = 0;
   int            hs_cnt    = 0;
   int            ct_cnt    = 0;
   longint        cur_limit = 0;
   int            pv_bad    = 0;
   int            full_seen = 0;
   logic [DW-1:0] q_data [$];
   longint        q_due  [$];
   logic [CW-1:0] exp_cnt [NM];

   lin_count_engine #(
      .DATA_W     (DW),
      .NUM_MASKS  (NM),
      .CNT_W      (CW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .restart_block (restart_block),
      .seed          (seed),
      .polynomial    (polynomial),
      .mask_i        (mask_i),
      .mask_o        (mask_o),
      .counter_limit (counter_limit),
      .pt_data       (pt_data),
      .pt_valid      (pt_valid),
      .pt_ready      (pt_ready),
      .ct_data       (ct_data),
      .ct_valid      (ct_valid),
      .counter       (counter),
      .samples       (samples),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Identity cipher: ciphertext equals plaintext, returned lat cycles after the handshake.
   always @(posedge clk) begin
      int  occ;
      bit  exp_pv;
      #2;
      if (!cipher_en) begin
         q_data.delete();
         q_due.delete();
         pt_ready = 1'b0;
         ct_valid = spur_ct;
         ct_data  = '0;
      end else begin
         occ = hs_cnt - ct_cnt;
         if (pv_chk) begin
            exp_pv = (hs_cnt < cur_limit) && (occ < FD);
            if (pt_valid !== exp_pv) pv_bad++;
            if (occ == FD) full_seen++;
         end
         if (q_due.size() > 0 && q_due[0] <= cyc + 1) begin
            ct_valid = 1'b1;
            ct_data  = q_data.pop_front();
            void'(q_due.pop_front());
            ct_cnt++;
         end else begin
            ct_valid = 1'b0;
            ct_data  = '0;
         end
         pt_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (pt_valid && pt_ready) begin
            q_data.push_back(pt_data);
            q_due.push_back(cyc + 1 + lat);
            hs_cnt++;
         end
      end
   end

   function automatic logic [NM*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic compute_model(input logic [DW-1:0] sd, input logic [DW-1:0] p,
                                input logic [NM*DW-1:0] mi, input logic [NM*DW-1:0] mo,
                                input int n);
      logic [DW-1:0] s;
      logic [DW-1:0] x;
      s = (sd == '0) ? 64'd1 : sd;
      for (int k = 0; k < NM; k++) exp_cnt[k] = '0;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < NM; k++) begin
            x = (s & mi[k*DW +: DW]) ^ (s & mo[k*DW +: DW]);
            if (^x == 1'b0) exp_cnt[k] = exp_cnt[k] + 1;
         end
         s = (s >> 1) ^ (s[0] ? p : 64'd0);
      end
   endtask

   task automatic start_run(input logic [DW-1:0] sd, input logic [DW-1:0] p,
                            input logic [NM*DW-1:0] mi, input logic [NM*DW-1:0] mo,
                            input logic [CW-1:0] lim, input int l, input bit rnd, input bit en);
      @(negedge clk);
      seed          = sd;
      polynomial    = p;
      mask_i        = mi;
      mask_o        = mo;
      counter_limit = lim;
      lat           = l;
      rnd_ready     = rnd;
      hs_cnt        = 0;
      ct_cnt        = 0;
      pv_bad        = 0;
      full_seen     = 0;
      cur_limit     = longint'(lim);
      cipher_en     = en;
      pv_chk        = en;
      start         = 1'b1;
      @(negedge clk);
      start         = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pt_valid: got %b want 0", pt_valid); end
      n_cmp++; if (pt_data !== '0) begin n_fail++; $display("FAIL reset_pt_data: got %h want 0", pt_data); end
      n_cmp++; if (counter !== '0) begin n_fail++; $display("FAIL reset_counter: got %h want 0", counter); end
      n_cmp++; if (samples !== '0) begin n_fail++; $display("FAIL reset_samples: got %h want 0", samples); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_identity_all_agree();
      int i;
      start_run(64'd1, POLY, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 64'h1000, 1, 1'b0, 1'b1);
      n_cmp++; if (pt_valid !== 1'b1) begin n_fail++; $display("FAIL ident_pv_first: got %b want 1", pt_valid); end
      n_cmp++; if (pt_data !== 64'h1) begin n_fail++; $display("FAIL ident_pt0: got %h want 1", pt_data); end
      @(negedge clk);
      n_cmp++; if (pt_data !== 64'h8000_0000_0000_000D) begin n_fail++; $display("FAIL ident_pt1: got %h want 800000000000000d", pt_data); end
      @(negedge clk);
      n_cmp++; if (pt_data !== 64'hC000_0000_0000_000B) begin n_fail++; $display("FAIL ident_pt2: got %h want c00000000000000b", pt_data); end
      i = 0;
      while (done !== 1'b1 && i < 6000) begin @(negedge clk); i++; end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL ident_done_timeout: done=%b want 1", done); end
      for (int k = 0; k < NM; k++) begin
         n_cmp++;
         if (counter[k*CW +: CW] !== 64'h1000) begin
            n_fail++; $display("FAIL ident_counter%0d: got %h want 1000", k, counter[k*CW +: CW]);
         end
      end
      n_cmp++; if (samples !== 64'h1000) begin n_fail++; $display("FAIL ident_samples: got %h want 1000", samples); end
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL ident_error: got %b want 0", error); end
      n_cmp++; if (pv_bad !== 0) begin n_fail++; $display("FAIL ident_pt_valid_profile: %0d bad cycles want 0", pv_bad); end
   endtask

   task automatic test_mask_pairs();
      int i;
      logic [NM*DW-1:0] mi;
      logic [NM*DW-1:0] mo;
      mi = pack4(64'h1, 64'h1, 64'h4, 64'hFF00);
      mo = pack4(64'h2, 64'h1, 64'h0, 64'h00FF);
      compute_model(64'h0123_4567_89AB_CDEF, POLY, mi, mo, 1024);
      start_run(64'h0123_4567_89AB_CDEF, POLY, mi, mo, 64'd1024, 1, 1'b0, 1'b1);
      i = 0;
      while (done !== 1'b1 && i < 3000) begin @(negedge clk); i++; end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL masks_done_timeout: done=%b want 1", done); end
      for (int k = 0; k < NM; k++) begin
         n_cmp++;
         if (counter[k*CW +: CW] !== exp_cnt[k]) begin
            n_fail++; $display("FAIL masks_counter%0d: got %h want %h", k, counter[k*CW +: CW], exp_cnt[k]);
         end
      end
      n_cmp++; if (counter[CW +: CW] !== 64'd1024) begin n_fail++; $display("FAIL masks_pair1_full: got %h want 400", counter[CW +: CW]); end
      n_cmp++; if (samples !== 64'd1024) begin n_fail++; $display("FAIL masks_samples: got %h want 400", samples); end
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL masks_error: got %b want 0", error); end
   endtask

   task automatic test_backpressure();
      int i;
      logic [NM*DW-1:0] mi;
      logic [NM*DW-1:0] mo;
      mi = pack4(64'h3, 64'hF0, 64'h8000_0000_0000_0001, 64'h5555);
      mo = pack4(64'h1, 64'h0F, 64'h2, 64'hAAAA);
      for (int run = 0; run < 2; run++) begin
         compute_model(64'hDEAD_BEEF_0BAD_F00D, POLY, mi, mo, (run == 0) ? 300 : 200);
         start_run(64'hDEAD_BEEF_0BAD_F00D, POLY, mi, mo, (run == 0) ? 64'd300 : 64'd200, 20, (run == 0), 1'b1);
         i = 0;
         while (done !== 1'b1 && i < 3000) begin @(negedge clk); i++; end
         n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp%0d_done_timeout: done=%b want 1", run, done); end
         for (int k = 0; k < NM; k++) begin
            n_cmp++;
            if (counter[k*CW +: CW] !== exp_cnt[k]) begin
               n_fail++; $display("FAIL bp%0d_counter%0d: got %h want %h", run, k, counter[k*CW +: CW], exp_cnt[k]);
            end
         end
         n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL bp%0d_error: got %b want 0", run, error); end
         n_cmp++; if (pv_bad !== 0) begin n_fail++; $display("FAIL bp%0d_pt_valid_profile: %0d bad cycles want 0", run, pv_bad); end
      end
      n_cmp++; if (full_seen == 0) begin n_fail++; $display("FAIL bp_fifo_full_reached: %0d full cycles want >0", full_seen); end
   endtask

   task automatic test_spurious_ct();
      int i;
      logic [NM*DW-1:0] mi;
      logic [NM*DW-1:0] mo;
      mi = pack4(64'h1, 64'h6, 64'h0, 64'h1);
      mo = pack4(64'h2, 64'h0, 64'h0, 64'h1);
      compute_model(64'h5, POLY, mi, mo, 16);
      start_run(64'h5, POLY, mi, mo, 64'd16, 1, 1'b0, 1'b1);
      i = 0;
      while (done !== 1'b1 && i < 200) begin @(negedge clk); i++; end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL spur_done_timeout: done=%b want 1", done); end
      cipher_en = 1'b0;
      pv_chk    = 1'b0;
      spur_ct   = 1'b1;
      @(negedge clk);
      spur_ct   = 1'b0;
      @(negedge clk);
      n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL spur_error: got %b want 1", error); end
      for (int k = 0; k < NM; k++) begin
         n_cmp++;
         if (counter[k*CW +: CW] !== exp_cnt[k]) begin
            n_fail++; $display("FAIL spur_counter%0d: got %h want %h", k, counter[k*CW +: CW], exp_cnt[k]);
         end
      end
      n_cmp++; if (samples !== 64'd16) begin n_fail++; $display("FAIL spur_samples: got %h want 10", samples); end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL spur_done_held: got %b want 1", done); end
   endtask

   task automatic test_limit_zero();
      int pv_seen;
      start_run(64'd0, POLY, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 64'd0, 1, 1'b0, 1'b0);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL lim0_done: got %b want 1", done); end
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL lim0_error_cleared: got %b want 0", error); end
      n_cmp++; if (pt_data !== 64'h1) begin n_fail++; $display("FAIL lim0_seed0_load: got %h want 1", pt_data); end
      n_cmp++; if (samples !== '0) begin n_fail++; $display("FAIL lim0_samples: got %h want 0", samples); end
      pv_seen = (pt_valid !== 1'b0) ? 1 : 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (pt_valid !== 1'b0) pv_seen++;
      end
      n_cmp++; if (pv_seen != 0) begin n_fail++; $display("FAIL lim0_pt_valid: %0d cycles high want 0", pv_seen); end
   endtask

   task automatic test_seed_zero();
      start_run(64'd0, POLY, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 64'd3, 1, 1'b0, 1'b0);
      n_cmp++; if (pt_valid !== 1'b1) begin n_fail++; $display("FAIL seed0_pt_valid: got %b want 1", pt_valid); end
      n_cmp++; if (pt_data !== 64'h1) begin n_fail++; $display("FAIL seed0_pt_data: got %h want 1", pt_data); end
      repeat (3) @(negedge clk);
      n_cmp++; if (pt_data !== 64'h1) begin n_fail++; $display("FAIL seed0_hold_no_ready: got %h want 1", pt_data); end
      restart_block = 1'b1;
      @(negedge clk);
      restart_block = 1'b0;
      n_cmp++; if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL seed0_restart_pv: got %b want 0", pt_valid); end
   endtask

   task automatic test_restart();
      int i;
      start_run(64'd1, POLY, pack4(1, 3, 7, 9), pack4(1, 2, 4, 8), 64'h1000, 1, 1'b0, 1'b1);
      i = 0;
      while (samples < 50 && i < 500) begin @(negedge clk); i++; end
      counter_limit = 64'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_start_ignored_in_run: done=%b want 0", done); end
      i = 0;
      while (samples < 100 && i < 500) begin @(negedge clk); i++; end
      n_cmp++; if (samples !== 64'd100) begin n_fail++; $display("FAIL restart_reach_100: samples=%h want 64", samples); end
      restart_block = 1'b1;
      cipher_en     = 1'b0;
      pv_chk        = 1'b0;
      @(negedge clk);
      restart_block = 1'b0;
      n_cmp++; if (counter !== '0) begin n_fail++; $display("FAIL restart_counter: got %h want 0", counter); end
      n_cmp++; if (samples !== '0) begin n_fail++; $display("FAIL restart_samples: got %h want 0", samples); end
      n_cmp++; if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL restart_pt_valid: got %b want 0", pt_valid); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", done); end
      repeat (3) @(negedge clk);
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL restart_idle_error: got %b want 0", error); end
      n_cmp++; if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL restart_idle_pt_valid: got %b want 0", pt_valid); end
   endtask

   task automatic test_async_reset();
      int i;
      start_run(64'd7, POLY, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 64'h1000, 1, 1'b0, 1'b1);
      i = 0;
      while (samples < 20 && i < 200) begin @(negedge clk); i++; end
      cipher_en = 1'b0;
      pv_chk    = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pt_valid: got %b want 0", pt_valid); end
      n_cmp++; if (pt_data !== '0) begin n_fail++; $display("FAIL arst_pt_data: got %h want 0", pt_data); end
      n_cmp++; if (counter !== '0) begin n_fail++; $display("FAIL arst_counter: got %h want 0", counter); end
      n_cmp++; if (samples !== '0) begin n_fail++; $display("FAIL arst_samples: got %h want 0", samples); end
      n_cmp++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL arst_done_error: got %b%b want 00", done, error); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_identity_all_agree();
      test_mask_pairs();
      test_backpressure();
      test_spurious_ct();
      test_limit_zero();
      test_seed_zero();
      test_restart();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
